// File: rtl/irrigation_scheduler.sv
// Irrigation valve scheduler: debounces a dry-soil/no-alarm request, waters for a
// bounded time, then enforces a cooldown. Counts completed watering runs.
module irrigation_scheduler #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned MIN_ON_CYCLES   = 3,
  parameter int unsigned MAX_ON_CYCLES   = 10,
  parameter int unsigned COOLDOWN_CYCLES = 5
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       alarm_state_i,
  input  logic       soil_humidity_i,
  output logic       valve_o,
  output logic [1:0] state_o,
  output logic       water_done_o,
  output logic       timeout_o,
  output logic [7:0] water_events_o
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_QUALIFY  = 2'd1,
    ST_WATER    = 2'd2,
    ST_COOLDOWN = 2'd3
  } state_t;

  localparam logic [15:0] DEB_LAST  = 16'(DEBOUNCE_CYCLES - 1);
  localparam logic [15:0] MIN_LAST  = 16'(MIN_ON_CYCLES - 1);
  localparam logic [15:0] MAX_LAST  = 16'(MAX_ON_CYCLES - 1);
  localparam logic [15:0] COOL_LAST = 16'(COOLDOWN_CYCLES - 1);

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic        valve_q, valve_d;
  logic        done_q, done_d;
  logic        timeout_q, timeout_d;
  logic [7:0]  events_q, events_d;
  logic        req_s;
  logic        exit_s;

  always_comb begin
    req_s     = ~(alarm_state_i | soil_humidity_i);
    state_d   = state_q;
    cnt_d     = cnt_q;
    timeout_d = 1'b0;
    exit_s    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (req_s) begin
          state_d = ST_QUALIFY;
          cnt_d   = 16'd0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_QUALIFY: begin
        if (!req_s) begin
          state_d = ST_IDLE;
          cnt_d   = 16'd0;
        end else if (cnt_q == DEB_LAST) begin
          state_d = ST_WATER;
          cnt_d   = 16'd0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      ST_WATER: begin
        // Alarm outranks the max-time limit, so a coincident alarm suppresses timeout.
        if (alarm_state_i) begin
          exit_s = 1'b1;
        end else if (cnt_q == MAX_LAST) begin
          exit_s    = 1'b1;
          timeout_d = 1'b1;
        end else if (soil_humidity_i && (cnt_q >= MIN_LAST)) begin
          exit_s = 1'b1;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
        if (exit_s) begin
          state_d = ST_COOLDOWN;
          cnt_d   = 16'd0;
        end else begin
          state_d = ST_WATER;
        end
      end
      ST_COOLDOWN: begin
        if (cnt_q == COOL_LAST) begin
          state_d = ST_IDLE;
          cnt_d   = 16'd0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 16'd0;
      end
    endcase

    done_d = exit_s;
    if (exit_s && (events_q != 8'd255)) begin
      events_d = events_q + 8'd1;
    end else begin
      events_d = events_q;
    end
    valve_d = (state_d == ST_WATER);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 16'd0;
      valve_q   <= 1'b0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
      events_q  <= 8'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      valve_q   <= valve_d;
      done_q    <= done_d;
      timeout_q <= timeout_d;
      events_q  <= events_d;
    end
  end

  assign valve_o        = valve_q;
  assign state_o        = state_q;
  assign water_done_o   = done_q;
  assign timeout_o      = timeout_q;
  assign water_events_o = events_q;

endmodule

// File: tb/tb_irrigation_scheduler.sv
// Directed bench for irrigation_scheduler at default parameters.
module tb_irrigation_scheduler;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic       alarm_state_i = 1'b0;
  logic       soil_humidity_i = 1'b1;
  logic       valve_o;
  logic [1:0] state_o;
  logic       water_done_o;
  logic       timeout_o;
  logic [7:0] water_events_o;

  int total = 0;
  int bad   = 0;

  irrigation_scheduler dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .alarm_state_i  (alarm_state_i),
    .soil_humidity_i(soil_humidity_i),
    .valve_o        (valve_o),
    .state_o        (state_o),
    .water_done_o   (water_done_o),
    .timeout_o      (timeout_o),
    .water_events_o (water_events_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Two reset edges, checks the cleared outputs, then leaves the soil dry.
  task automatic do_reset();
    rst_i = 1'b1;
    alarm_state_i = 1'b0;
    soil_humidity_i = 1'b1;
    step();
    step();
    check("rst_state", state_o, 0);
    check("rst_valve", valve_o, 0);
    check("rst_done", water_done_o, 0);
    check("rst_timeout", timeout_o, 0);
    check("rst_events", water_events_o, 0);
    rst_i = 1'b0;
    soil_humidity_i = 1'b0;
  endtask

  initial begin
    int exp_st;
    int p;
    int vcount;

    // Dry for 3 cycles then wet: qualify aborts, no watering.
    do_reset();
    for (int e = 0; e < 3; e++) begin
      step();
      check("s2_qualify", state_o, 1);
    end
    soil_humidity_i = 1'b1;
    step();
    check("s2_back_idle", state_o, 0);
    for (int e = 0; e < 6; e++) begin
      step();
      check("s2_valve", valve_o, 0);
    end
    check("s2_events", water_events_o, 0);

    // Wet on first WATER cycle: valve open exactly 3 cycles.
    do_reset();
    for (int e = 0; e < 5; e++) step();
    check("s3_water", state_o, 2);
    soil_humidity_i = 1'b1;
    vcount = 1;
    for (int i = 0; i < 10; i++) begin
      step();
      vcount += int'(valve_o);
      if (i == 2) begin
        check("s3_state", state_o, 3);
        check("s3_done", water_done_o, 1);
        check("s3_timeout", timeout_o, 0);
      end
    end
    check("s3_on_cycles", vcount, 3);
    check("s3_events", water_events_o, 1);

    // Alarm on the 7th WATER cycle.
    do_reset();
    for (int e = 0; e < 11; e++) step();
    check("s4_water", state_o, 2);
    alarm_state_i = 1'b1;
    step();
    check("s4_valve", valve_o, 0);
    check("s4_state", state_o, 3);
    check("s4_done", water_done_o, 1);
    check("s4_timeout", timeout_o, 0);
    for (int e = 0; e < 4; e++) begin
      step();
      check("s4_cool", state_o, 3);
    end
    step();
    check("s4_idle", state_o, 0);
    step();
    check("s4_stay_idle", state_o, 0);
    alarm_state_i = 1'b0;

    // Alarm coincident with cnt = 9.
    do_reset();
    for (int e = 0; e < 14; e++) step();
    check("s5_water", state_o, 2);
    alarm_state_i = 1'b1;
    step();
    check("s5_state", state_o, 3);
    check("s5_done", water_done_o, 1);
    check("s5_timeout", timeout_o, 0);
    check("s5_events", water_events_o, 1);
    alarm_state_i = 1'b0;

    // Continuous dry soil: 20-edge period of 4 qualify, 10 water, 5 cooldown, 1 idle.
    do_reset();
    for (int e = 0; e <= 48; e++) begin
      step();
      p = e % 20;
      if (p < 4) exp_st = 1;
      else if (p < 14) exp_st = 2;
      else if (p < 19) exp_st = 3;
      else exp_st = 0;
      check("s1_state", state_o, exp_st);
      check("s1_valve", valve_o, (exp_st == 2) ? 1 : 0);
      check("s1_done", water_done_o, (p == 14) ? 1 : 0);
      check("s1_timeout", timeout_o, (p == 14) ? 1 : 0);
      check("s1_events", water_events_o, int'(e >= 14) + int'(e >= 34));
    end

    // Reset on the 5th WATER cycle.
    rst_i = 1'b1;
    step();
    check("s6_valve", valve_o, 0);
    check("s6_state", state_o, 0);
    check("s6_events", water_events_o, 0);
    check("s6_done", water_done_o, 0);
    check("s6_timeout", timeout_o, 0);
    rst_i = 1'b0;

    // 300 timeout-terminated waterings: counter saturates at 255.
    for (int e = 0; e <= 5994; e++) begin
      step();
      if (e == 5074) check("sat_254", water_events_o, 254);
      if (e == 5094) check("sat_255", water_events_o, 255);
      if (e == 5994) begin
        check("sat_hold", water_events_o, 255);
        check("sat_done", water_done_o, 1);
        check("sat_state", state_o, 3);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/irrigation_scheduler.md
IRRIGATION_SCHEDULER -- requirements
Module: irrigation_scheduler

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clk_i samples all state on its rising edge and rst_i is sampled on that edge.
REQ-002 The block SHALL have the following parameters (name, default, meaning):
- DEBOUNCE_CYCLES, 4, consecutive request cycles required before watering.
- MIN_ON_CYCLES, 3, minimum valve-on time.
- MAX_ON_CYCLES, 10, maximum valve-on time.
- COOLDOWN_CYCLES, 5, forced valve-off time after watering.
REQ-003 The block SHALL have the following ports (name, direction, width, meaning):
- clk_i, in, 1, clock.
- rst_i, in, 1, synchronous active-high reset.
- alarm_state_i, in, 1, 1 = alarm active, so irrigation is forbidden.
- soil_humidity_i, in, 1, 1 = soil wet, 0 = soil dry.
- valve_o, out, 1, 1 = irrigation on.
- state_o, out, 2, current state: IDLE=0, QUALIFY=1, WATER=2, COOLDOWN=3.
- water_done_o, out, 1, one-cycle pulse on each exit from WATER.
- timeout_o, out, 1, one-cycle pulse when WATER ends by the MAX_ON_CYCLES limit.
- water_events_o, out, 8, completed watering count, saturating.
REQ-004 All parameters SHALL satisfy 1 <= value <= 65535 and MIN_ON_CYCLES <= MAX_ON_CYCLES; internal counters SHALL be 16 bits wide.

Function
REQ-005 The watering request SHALL be defined as req = NOR(alarm_state_i, soil_humidity_i), i.e. no alarm and dry soil.
REQ-006 All outputs SHALL be registered; valve_o SHALL be 1 exactly when state_o = WATER.
REQ-007 IDLE: if req = 1, the state SHALL go to QUALIFY with cnt = 0; otherwise it SHALL stay in IDLE.
REQ-008 QUALIFY: if req = 0, the state SHALL return to IDLE; if req = 1 and cnt = DEBOUNCE_CYCLES-1, it SHALL go to WATER with cnt = 0; otherwise cnt SHALL increment.
REQ-009 Latency: with req held high from edge 0, valve_o SHALL first be 1 after edge DEBOUNCE_CYCLES.
REQ-010 WATER exit conditions SHALL be evaluated in this priority order, each exit going to COOLDOWN with cnt = 0:
- (a) alarm_state_i = 1 SHALL exit regardless of cnt.
- (b) cnt = MAX_ON_CYCLES-1 SHALL exit and assert timeout_o.
- (c) soil_humidity_i = 1 and cnt >= MIN_ON_CYCLES-1 SHALL exit.
- Otherwise cnt SHALL increment.
REQ-011 Valve-on duration SHALL therefore be exactly MAX_ON_CYCLES cycles on timeout, and at least MIN_ON_CYCLES cycles unless an alarm occurs.
REQ-012 Wet soil seen while cnt < MIN_ON_CYCLES-1 SHALL be ignored; its later persistence SHALL cause exit once the minimum is met.
REQ-013 water_done_o SHALL pulse high for one cycle, coincident with the first COOLDOWN cycle, on every WATER exit.
REQ-014 timeout_o SHALL pulse with water_done_o only for exit (b); when alarm and the max limit coincide, timeout_o SHALL stay 0.
REQ-015 water_events_o SHALL increment by 1 on every WATER exit and SHALL saturate at 255.
REQ-016 COOLDOWN: the state SHALL remain in COOLDOWN for exactly COOLDOWN_CYCLES cycles, ignoring all inputs, then go to IDLE; IDLE SHALL require req again before re-qualifying.
REQ-017 Alarm in QUALIFY SHALL return the state to IDLE (req = 0); alarm in IDLE or COOLDOWN SHALL have no effect beyond keeping req low.

Reset
REQ-018 rst_i = 1 SHALL, on the next edge and in any state, set state to IDLE, cnt to 0, valve_o, water_done_o and timeout_o to 0, and water_events_o to 0.
REQ-019 Reset SHALL take priority over all transitions, including mid-WATER, where the valve SHALL close on that edge with no water_done_o pulse.

Verification (default parameters)
REQ-020 The bench SHALL cover these directed scenarios:
- Alarm 0, soil dry constant from edge 0 -> valve_o high after edge 4 for exactly 10 cycles; timeout_o and water_done_o pulse; 5 cycles off; 1 cycle IDLE; repeat; water_events_o = 1, 2, ...
- Soil dry for 3 cycles, then wet -> state 0→1→0, valve_o never 1, water_events_o = 0.
- Soil wet on the 1st WATER cycle and held -> valve_o high exactly 3 cycles; water_done_o = 1, timeout_o = 0.
- Alarm = 1 on the 7th WATER cycle -> valve_o 0 the next cycle; water_done_o = 1, timeout_o = 0; COOLDOWN lasts 5 cycles.
- Alarm coincident with cnt = 9 in WATER -> timeout_o = 0, water_done_o = 1.
- rst_i on the 5th WATER cycle -> next cycle valve_o = 0, state_o = 0, water_events_o = 0, no pulses; 300 consecutive completed waterings -> water_events_o holds 255.
